// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Desc     : Instruction-fetch stage. Holds the PC, issues one instruction
//            memory request at a time, hands fetched words to decode and
//            accepts taken-branch / JAL redirects from execute.
// Options  : define INST_FETCH_PERF_EN to add perf_fetched / perf_flushed
//            event counters as extra output ports.
// Revision : 1.0 - initial release
// ============================================================================

module inst_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic            fetch_err
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_id_valid;
    logic            w_id_valid_nxt;
    logic            w_capture;
    logic [XLEN-1:0] r_id_inst;
    logic [XLEN-1:0] r_id_pc;
    logic            r_fetch_err;
    logic            w_req_fire;
    logic            w_misaligned;
    logic [XLEN-1:0] w_redirect_pc;

    // Targets are always word aligned; a misaligned target has its low bits
    // cleared and is reported through fetch_err.
    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_misaligned   = (redirect_pc[1:0] != 2'b00);
    assign w_req_fire     = (r_state == S_REQ) && imem_req_ready;

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_addr      = r_pc;
    assign id_valid       = r_id_valid;
    assign id_inst        = r_id_inst;
    assign id_pc          = r_id_pc;
    assign id_opcode      = r_id_inst[6:0];
    assign fetch_err      = r_fetch_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic; a redirect always wins over the
    // normal flow and marks any request still in flight as stale (drop).
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_id_valid_nxt = r_id_valid;
        w_capture      = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
            end
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (w_req_fire) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (imem_resp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_capture      = 1'b1;
                        w_id_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + {{(XLEN-3){1'b0}}, 3'b100};
                        w_state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_id_valid_nxt = 1'b0;
                    w_pc_nxt       = w_redirect_pc;
                    w_state_nxt    = S_REQ;
                end else if (id_ready) begin
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // PC, stale-response flag, decode-valid and the misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_id_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_id_valid  <= w_id_valid_nxt;
            r_fetch_err <= redirect_valid && w_misaligned;
        end
    end

    // Capture the instruction word and its PC for decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_inst <= '0;
            r_id_pc   <= '0;
        end else if (w_capture) begin
            r_id_inst <= imem_resp_data;
            r_id_pc   <= r_pc;
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic        w_discard;

    // A response is thrown away when it is stale or meets a redirect.
    assign w_discard = (r_state == S_WAIT) && imem_resp_valid &&
                       (r_drop || redirect_valid);

    // Delivered and discarded instruction counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_flushed <= 32'd0;
        end else begin
            if (r_id_valid && id_ready) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_discard) begin
                r_perf_flushed <= r_perf_flushed + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Desc     : Self-checking bench for inst_fetch. A memory model answers
//            requests with random latency; a scoreboard predicts the PC of
//            every instruction handed to decode from the redirect stream.
// Revision : 1.0 - initial release
// ============================================================================

module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic        fetch_err;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_opcode       (id_opcode),
        .fetch_err       (fetch_err)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];    // PC of the next instruction decode must see
    logic [31:0] redir_q[$];  // redirect targets issued, not yet applied
    int          n_fetched = 0;
    int          n_resp = 0;
    int          n_pres = 0;
    int          mem_w = 0;   // extra response latency, -1 = random
    bit          ready_rand = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: one request at a time, response 1..4 cycles later.
    initial begin
        bit          hs;
        logic [31:0] a;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(posedge clk);
            hs = rst_n && imem_req_valid && imem_req_ready;
            a  = imem_addr;
            if (hs) chk("one_outstanding", {31'd0, mem_busy && !imem_resp_valid}, 32'd0);
            #1;
            if (!rst_n) begin
                mem_busy        = 1'b0;
                imem_resp_valid = 1'b0;
            end else begin
                if (imem_resp_valid) begin
                    imem_resp_valid = 1'b0;
                    mem_busy        = 1'b0;
                end else if (mem_busy && mem_cnt > 0) begin
                    mem_cnt--;
                end
                if (hs) begin
                    mem_busy = 1'b1;
                    mem_addr = a;
                    mem_cnt  = (mem_w < 0) ? int'($urandom_range(0, 3)) : mem_w;
                end
                if (mem_busy && mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memf(mem_addr);
                end
            end
            if (!imem_resp_valid) imem_resp_data = $urandom;
            imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor: looks at the cycle about to be clocked.
    initial begin
        bit          prev_valid;
        bit          exp_err;
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] e;
        logic [31:0] d;
        prev_valid = 1'b0;
        exp_err    = 1'b0;
        held_pc    = 32'd0;
        held_inst  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                exp_err    = 1'b0;
            end else begin
                chk("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
                if (id_valid) begin
                    chk("no_req_in_hold", {31'd0, imem_req_valid}, 32'd0);
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL scoreboard_empty: actual=%h expected=none", id_pc);
                        end else begin
                            e = exp_q.pop_front();
                            d = memf(e);
                            chk("id_pc", id_pc, e);
                            chk("id_inst", id_inst, d);
                            chk("id_opcode", {25'd0, id_opcode}, {25'd0, d[6:0]});
                            exp_q.push_back(e + 32'd4);
                            n_pres++;
                        end
                        held_pc   = id_pc;
                        held_inst = id_inst;
                    end else begin
                        chk("hold_pc_stable", id_pc, held_pc);
                        chk("hold_inst_stable", id_inst, held_inst);
                    end
                end
                prev_valid = id_valid;
                if (imem_req_valid && imem_req_ready && !redirect_valid && exp_q.size() > 0)
                    chk("req_addr", imem_addr, exp_q[0]);
                if (id_valid && id_ready) n_fetched++;
                if (imem_resp_valid) n_resp++;
                exp_err = redirect_valid && (redirect_pc[1:0] != 2'b00);
                if (redirect_valid) begin
                    exp_q.delete();
                    if (redir_q.size() > 0) begin
                        e = redir_q.pop_front();
                        exp_q.push_back({e[31:2], 2'b00});
                    end else begin
                        n_chk++;
                        n_err++;
                        $display("FAIL redirect_log: actual=%h expected=logged target", redirect_pc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idv(input string name, input int budget);
        int k;
        k = 0;
        while (!id_valid && k < budget) begin
            cyc();
            k++;
        end
        chk(name, {31'd0, id_valid}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        redir_q.push_back(t);
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, "_id_inst"}, id_inst, 32'd0);
        chk({tag, "_id_pc"}, id_pc, 32'd0);
        chk({tag, "_id_opcode"}, {25'd0, id_opcode}, 32'd0);
        chk({tag, "_fetch_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        else                            t = $urandom_range(0, 255) << 2;
        if ($urandom_range(0, 3) == 0)  t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        int k;
        bit last;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        exp_q.push_back(RST_PC);
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst_n    = 1'b1;
        id_ready = 1'b1;

        // First fetches: wrap from the top of the address space to 0.
        k = 0;
        while (!imem_req_valid && k < 10) begin cyc(); k++; end
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_addr, RST_PC);
        wait_idv("first_id_valid", 10);
        chk("first_id_pc", id_pc, RST_PC);
        cyc();
        wait_idv("second_id_valid", 10);
        chk("wrap_id_pc", id_pc, 32'd0);
        chk("nop_opcode", {25'd0, id_opcode}, 32'h13);
        id_ready = 1'b0;

        // Back-pressure from decode.
        repeat (5) begin
            cyc();
            chk("bp_id_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_id_pc", id_pc, 32'd0);
            chk("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        id_ready = 1'b1;
        cyc();
        chk("bp_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_next_req_addr", imem_addr, 32'h4);

        // Redirect while a slow response is outstanding.
        mem_w = 2;
        k = 0;
        while (!mem_busy && k < 10) begin cyc(); k++; end
        chk("wait_busy", {31'd0, mem_busy}, 32'd1);
        redirect(32'h100);
        wait_idv("wait_redir_valid", 20);
        chk("wait_redir_pc", id_pc, 32'h100);

        // Redirect in the same cycle as the response.
        mem_w = 0;
        cyc();
        k = 0;
        while (!imem_resp_valid && k < 20) begin cyc(); k++; end
        chk("same_cycle_resp", {31'd0, imem_resp_valid}, 32'd1);
        redirect(32'h200);
        chk("same_cycle_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("same_cycle_req_addr", imem_addr, 32'h200);
        wait_idv("same_cycle_valid", 20);
        chk("same_cycle_pc", id_pc, 32'h200);

        // Misaligned redirect.
        cyc();
        redirect(32'h102);
        chk("misalign_err_high", {31'd0, fetch_err}, 32'd1);
        cyc();
        chk("misalign_err_low", {31'd0, fetch_err}, 32'd0);
        wait_idv("misalign_valid", 20);
        chk("misalign_pc", id_pc, 32'h100);

        // Random traffic.
        mem_w      = -1;
        ready_rand = 1'b1;
        last       = 1'b0;
        repeat (1500) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if (!last && $urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = pick_target();
                redir_q.push_back(redirect_pc);
                last = 1'b1;
            end else begin
                redirect_valid = 1'b0;
                last = 1'b0;
            end
            cyc();
        end
        redirect_valid = 1'b0;
        ready_rand     = 1'b0;
        id_ready       = 1'b0;
        repeat (20) cyc();
        chk("quiesce_hold", {31'd0, id_valid}, 32'd1);
`ifdef INST_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, n_fetched);
        chk("perf_flushed", perf_flushed, n_resp - n_pres);
`endif

        // Asynchronous reset while a response is pending.
        id_ready = 1'b1;
        mem_w    = 3;
        k = 0;
        while (!mem_busy && k < 20) begin cyc(); k++; end
        chk("rst_wait_busy", {31'd0, mem_busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        redir_q.delete();
        n_fetched = 0;
        n_resp    = 0;
        n_pres    = 0;
        #1;
        check_reset_outputs("async_reset");
`ifdef INST_FETCH_PERF_EN
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_flushed_rst", perf_flushed, 32'd0);
`endif
        cyc();
        cyc();
        mem_w = 0;
        rst_n = 1'b1;
        wait_idv("post_rst_valid", 20);
        chk("post_rst_pc", id_pc, RST_PC);
        cyc();
        wait_idv("post_rst_valid2", 20);
        chk("post_rst_wrap_pc", id_pc, 32'd0);
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder.
- Holds the PC and issues one request at a time to instruction memory over a valid/ready request channel plus a valid response channel.
- Presents the fetched instruction, its PC and its opcode field (bits 6:0) to decode.
- Accepts taken-branch/JAL redirects from the execute side.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN, 32, address and instruction width; only 32 supported.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  imem accepts request.
- imem_addr  output  XLEN  fetch address (= pc).
- imem_resp_valid  input  1  response data valid, ≥1 cycle after accept.
- imem_resp_data  input  XLEN  fetched instruction word.
- redirect_valid  input  1  taken branch/JAL, single-cycle pulse.
- redirect_pc  input  XLEN  redirect target.
- id_valid  output  1  id_inst/id_pc/id_opcode valid.
- id_ready  input  1  decode consumes the instruction.
- id_inst  output  XLEN  instruction word.
- id_pc  output  XLEN  PC of id_inst.
- id_opcode  output  7  id_inst[6:0]; drives the control decoder.
- fetch_err  output  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset (rst_n=0, asynchronous): state=BOOT, pc=RESET_PC, drop=0.
  - Outputs: imem_req_valid=0, id_valid=0, id_inst=0, id_pc=0, id_opcode=0, fetch_err=0.
  - imem_addr=RESET_PC.
  - Reset mid-operation abandons any outstanding request. The memory model must tolerate this.
- All state is registered. imem_addr=pc. imem_req_valid=(state==REQ). id_opcode=id_inst[6:0].
- At most one outstanding request.
- FSM states: BOOT, REQ, WAIT, HOLD.
- BOOT: one cycle after reset release, then REQ. Redirect in BOOT: load pc, then REQ.
- REQ:
  - Handshake (req_valid & req_ready) -> WAIT.
  - Redirect without handshake: pc<=redirect_pc, stay in REQ. The new address is driven next cycle.
  - Redirect with handshake in the same cycle: pc<=redirect_pc, drop<=1, -> WAIT.
- WAIT:
  - resp_valid with drop=0 and no redirect: id_inst<=resp_data, id_pc<=pc, id_valid<=1, pc<=pc+4 (mod 2^32), -> HOLD.
  - resp_valid with drop=1: discard the response, drop<=0, -> REQ.
  - Redirect without resp_valid: pc<=redirect_pc, drop<=1, stay in WAIT.
  - Redirect with resp_valid in the same cycle: discard the response, pc<=redirect_pc, drop<=0, -> REQ.
- HOLD:
  - id outputs stay stable while id_ready=0.
  - id_ready=1: id_valid<=0, -> REQ.
  - Redirect (with or without id_ready): id_valid<=0, pc<=redirect_pc, -> REQ. The redirect wins.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - fetch_err=1 for exactly the next cycle.
  - Otherwise handled like a normal redirect.
- Throughput: one instruction per 3 cycles with zero-wait memory (REQ, WAIT, HOLD). Back-pressure extends HOLD.
- Wrap-around: pc=32'hFFFF_FFFC increments to 32'h0000_0000 with no flag.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- When defined, two output ports are added:
  - perf_fetched (32): increments on every instruction delivered (id_valid & id_ready).
  - perf_flushed (32): increments on every response discarded by drop or by a same-cycle redirect.
  - Both are reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and the behaviour above is unchanged.

Test Plan:
- Reset release, zero-wait imem returning 32'h00000013 -> first req at 32'h0; id_valid with id_pc=0, id_opcode=7'h13; next req at 32'h4.
- Hold id_ready=0 for 5 cycles in HOLD -> id_inst/id_pc stable, no new request, imem_req_valid=0; release -> next req at pc+4.
- Redirect to 32'h100 during WAIT (response at pc 32'h8 arrives 2 cycles later) -> response dropped, id_valid stays 0, next req at 32'h100.
- Redirect to 32'h200 in the same cycle as resp_valid -> response discarded, immediate REQ at 32'h200; with INST_FETCH_PERF_EN, perf_flushed increments by 1.
- Redirect to 32'h102 -> fetch_err high one cycle, next req at 32'h100.
- RESET_PC=32'hFFFF_FFFC -> first fetch at 32'hFFFF_FFFC, second at 32'h0; assert rst_n low during WAIT -> all outputs return to reset values asynchronously.
